mutex_lock_sequencer: RTL

//  Shares one Avalon hardware mutex slave among NUM_REQ local requesters. Picks a

---
 rtl/mutex_lock_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mutex_lock_sequencer.sv
// mutex_lock_sequencer: round-robin arbiter running the Avalon hardware-mutex acquire/retry/release sequence.
// Define MUTEX_LOCK_SEQ_BACKOFF_EN for exponential retry backoff (2^k cycles, k saturating at BACKOFF_LOG).
module mutex_lock_sequencer #(
    parameter int          NUM_REQ     = 4,
    parameter logic [15:0] OWNER_BASE  = 16'h0001,
    parameter logic [15:0] LOCK_VALUE  = 16'h0001,
    parameter int          BACKOFF_LOG = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] release_req,
    output logic [NUM_REQ-1:0] grant,
    output logic               acq_fail,
    output logic               busy,
    output logic               m_address,
    output logic               m_chipselect,
    output logic               m_write,
    output logic               m_read,
    output logic [31:0]        m_writedata,
    input  logic [31:0]        m_readdata,
    input  logic               m_waitrequest
);
    localparam int SW = $clog2(NUM_REQ);
    localparam int IW = SW + 1;
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_REQ - 1);

    typedef enum logic [2:0] {IDLE, ACQ_WR, ACQ_RD, CHECK, BACKOFF, HOLD, REL_WR} state_t;

    state_t        state;
    logic [SW-1:0] rr_ptr, sel, pick;
    logic [IW-1:0] idx;
    logic [15:0]   owner;
    logic [31:0]   rdata;
    logic          retry;

    if (NUM_REQ < 2 || NUM_REQ > 8 || BACKOFF_LOG < 1 || OWNER_BASE == 16'h0 || LOCK_VALUE == 16'h0) begin : g_param_check
        $error("mutex_lock_sequencer: illegal parameter value");
    end

    assign m_address = 1'b0;

    // Scan from the highest offset down so the lowest offset at/after rr_ptr wins.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + IW'(i);
            idx = idx >= IW'(NUM_REQ) ? idx - IW'(NUM_REQ) : idx;
            if (req[idx[SW-1:0]]) pick = idx[SW-1:0];
        end
    end

`ifdef MUTEX_LOCK_SEQ_BACKOFF_EN
    localparam int KW = $clog2(BACKOFF_LOG + 1);
    localparam logic [BACKOFF_LOG-1:0] CNT_ONE = 1;
    logic [KW-1:0]          bo_exp;
    logic [BACKOFF_LOG-1:0] bo_cnt;

    assign retry = bo_cnt == '0;

    // Loading (1 << k) - 1 wraps to all-ones when k == BACKOFF_LOG, giving the 2^BACKOFF_LOG cap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bo_exp <= '0;
            bo_cnt <= '0;
        end else if (state == IDLE) begin
            bo_exp <= '0;
            bo_cnt <= '0;
        end else if (state == CHECK) begin
            bo_cnt <= (CNT_ONE << bo_exp) - CNT_ONE;
            bo_exp <= bo_exp == KW'(BACKOFF_LOG) ? bo_exp : bo_exp + KW'(1);
        end else if (state == BACKOFF && !retry) begin
            bo_cnt <= bo_cnt - CNT_ONE;
        end
    end
`else
    assign retry = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            sel          <= '0;
            owner        <= '0;
            rdata        <= '0;
            grant        <= '0;
            acq_fail     <= 1'b0;
            busy         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_read       <= 1'b0;
            m_writedata  <= '0;
        end else begin
            acq_fail <= 1'b0;
            case (state)
                IDLE: if (|req) begin
                    sel          <= pick;
                    owner        <= OWNER_BASE + 16'(pick);
                    m_writedata  <= {OWNER_BASE + 16'(pick), LOCK_VALUE};
                    m_chipselect <= 1'b1;
                    m_write      <= 1'b1;
                    busy         <= 1'b1;
                    state        <= ACQ_WR;
                end
                ACQ_WR: if (!m_waitrequest) begin
                    m_write     <= 1'b0;
                    m_writedata <= '0;
                    m_read      <= 1'b1;
                    state       <= ACQ_RD;
                end
                ACQ_RD: if (!m_waitrequest) begin
                    rdata        <= m_readdata;
                    m_read       <= 1'b0;
                    m_chipselect <= 1'b0;
                    state        <= CHECK;
                end
                CHECK: if (rdata == {owner, LOCK_VALUE}) begin
                    grant <= NUM_REQ'(1) << sel;
                    state <= HOLD;
                end else begin
                    acq_fail <= 1'b1;
                    state    <= BACKOFF;
                end
                BACKOFF: if (!req[sel]) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (retry) begin
                    m_writedata  <= {owner, LOCK_VALUE};
                    m_chipselect <= 1'b1;
                    m_write      <= 1'b1;
                    state        <= ACQ_WR;
                end
                HOLD: if (release_req[sel] || !req[sel]) begin
                    grant        <= '0;
                    m_writedata  <= {owner, 16'h0000};
                    m_chipselect <= 1'b1;
                    m_write      <= 1'b1;
                    state        <= REL_WR;
                end
                REL_WR: if (!m_waitrequest) begin
                    m_writedata  <= '0;
                    m_chipselect <= 1'b0;
                    m_write      <= 1'b0;
                    busy         <= 1'b0;
                    rr_ptr       <= sel == SEL_LAST ? '0 : sel + SW'(1);
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
